// File: rtl/nqcpu_pkg.sv
// rtl/nqcpu_pkg.sv - shared FSM type and default parameters for the instruction prefetch unit
package nqcpu_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_PC_STEP  = 2;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } pf_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue with flush and wrap-around pointers
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q != CNT_W'(DEPTH));

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - single-outstanding instruction prefetcher feeding a decoder queue
module prefetch_unit
    import nqcpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INSTR_W-1:0]     mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_W-1:0]     instr,
    output logic [ADDR_W-1:0]      instr_pc,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pf_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [INSTR_W+ADDR_W-1:0] head_data;

    // Redirect wins over a pop: the queue is flushed anyway.
    assign pop = !fifo_empty && instr_ready && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && (int'(fifo_count) + 1 <= DEPTH)) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d  = 1'b0;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                    state_d    = redirect ? DROP : WAIT;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push    = !redirect;
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // A request caught by redirect before its grant is still owed to memory.
                if (mem_req_q) begin
                    if (mem_gnt) begin
                        mem_req_d = 1'b0;
                    end
                end else if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i ({mem_rdata, mem_addr_q}),
        .pop_i       (pop),
        .head_data_o (head_data),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = !fifo_empty;
    assign instr       = head_data[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc    = head_data[ADDR_W-1:0];
    assign dbg_count   = fifo_count;

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - self-checking bench for prefetch_unit
module tb_prefetch_unit;

    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [CW-1:0] dbg_count;

    always #5 clk = ~clk;

    prefetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .PC_STEP  (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dbg_count   (dbg_count)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] data_of(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    typedef struct {
        logic          gnt;
        logic          rvalid;
        logic          ready;
        logic [IW-1:0] rdata;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [IW-1:0] rd,
                                input logic er, input logic [AW-1:0] ea,
                                input logic ev, input logic [AW-1:0] ep, input logic [CW-1:0] ec);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.ready = 1'b1; v.rdata = rd;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_cnt = ec;
        return v;
    endfunction

    // Memory/consumer model: one grant-to-response latency per request, and the
    // decoder must see a contiguous PC stream restarting at every redirect target.
    bit            mo_out;
    logic [AW-1:0] mo_addr;
    int            mo_dly;
    int            gnt_pct, lat_lo, lat_hi, rdy_pct, redir_pct;
    bit            force_redir;
    logic [AW-1:0] force_pc;
    bit            prev_stall;
    logic [AW-1:0] prev_addr;
    bit            last_gnt;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] gnt_addrs[$];
    logic [AW-1:0] pop_pcs[$];

    task automatic clear_model();
        mo_out = 1'b0; prev_stall = 1'b0; last_gnt = 1'b0; force_redir = 1'b0;
        exp_pc = 16'h0000;
        gnt_addrs.delete();
        pop_pcs.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        bit was_out;
        was_out    = mo_out;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        last_gnt   = 1'b0;
        if (mo_out) begin
            if (mo_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(mo_addr);
                mo_out     = 1'b0;
            end else begin
                mo_dly--;
            end
        end
        if (prev_stall) begin
            check("req_held", 32'(mem_req), 32'(1));
            check("addr_held", 32'(mem_addr), 32'(prev_addr));
        end
        if (mem_req && (int'($urandom_range(99, 0)) < gnt_pct)) begin
            check("single_outstanding", 32'(was_out), 32'(0));
            mem_gnt  = 1'b1;
            mo_out   = 1'b1;
            mo_addr  = mem_addr;
            mo_dly   = int'($urandom_range(lat_hi, lat_lo));
            last_gnt = 1'b1;
            gnt_addrs.push_back(mem_addr);
        end
        prev_stall  = mem_req && !mem_gnt;
        prev_addr   = mem_addr;
        instr_ready = (int'($urandom_range(99, 0)) < rdy_pct);
        redirect    = 1'b0;
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else if (int'($urandom_range(99, 0)) < redir_pct) begin
            redirect    = 1'b1;
            redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFC : 16'($urandom);
        end
        if (redirect) begin
            exp_pc = redirect_pc;
        end else if (instr_valid && instr_ready) begin
            check("pop_pc", 32'(instr_pc), 32'(exp_pc));
            check("pop_instr", 32'(instr), 32'(data_of(instr_pc)));
            pop_pcs.push_back(instr_pc);
            exp_pc = instr_pc + 16'd2;
        end
        check("count_bound", 32'(dbg_count <= CW'(DEPTH)), 32'(1));
        check("valid_vs_count", 32'(instr_valid), 32'(dbg_count != '0));
        @(posedge clk);
        @(negedge clk);
        if (redirect) begin
            check("flush_valid", 32'(instr_valid), 32'(0));
        end
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0] = mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            vecs[1 + 3*k] = mk(1'b1, 1'b0, '0, 1'b1, 16'(2*k), 1'b0, '0, '0);
            vecs[2 + 3*k] = mk(1'b0, 1'b1, data_of(16'(2*k)), 1'b0, '0, 1'b0, '0, '0);
            vecs[3 + 3*k] = mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 16'(2*k), 3'd1);
        end

        // In-order fetch with immediate grant and 1-cycle response.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            check($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].exp_pc));
                check($sformatf("vec%0d_instr", i), 32'(instr), 32'(data_of(vecs[i].exp_pc)));
            end
            check($sformatf("vec%0d_cnt", i), 32'(dbg_count), 32'(vecs[i].exp_cnt));
            mem_gnt     = vecs[i].gnt;
            mem_rvalid  = vecs[i].rvalid;
            mem_rdata   = vecs[i].rdata;
            instr_ready = vecs[i].ready;
            @(posedge clk);
            @(negedge clk);
        end

        // Stalled decoder: queue fills to DEPTH, then one pop allows one fetch.
        do_reset();
        gnt_pct = 100; lat_lo = 0; lat_hi = 0; rdy_pct = 0; redir_pct = 0;
        repeat (40) tick();
        check("full_fetches", 32'(gnt_addrs.size()), 32'(4));
        check("full_req_low", 32'(mem_req), 32'(0));
        check("full_count", 32'(dbg_count), 32'(4));
        rdy_pct = 100;
        tick();
        rdy_pct = 0;
        repeat (30) tick();
        check("refill_fetches", 32'(gnt_addrs.size()), 32'(5));
        check("refill_count", 32'(dbg_count), 32'(4));
        if (gnt_addrs.size() == 5) check("refill_addr", 32'(gnt_addrs[4]), 32'h0008);

        // Redirect while waiting for a slow response.
        do_reset();
        gnt_pct = 100; lat_lo = 2; lat_hi = 2; rdy_pct = 100;
        for (int i = 0; i < 20 && !last_gnt; i++) tick();
        check("wait_reached", 32'(last_gnt), 32'(1));
        force_redir = 1'b1; force_pc = 16'h0100;
        gnt_addrs.delete(); pop_pcs.delete();
        tick();
        for (int i = 0; i < 40 && pop_pcs.size() == 0; i++) tick();
        check("redir_pop_seen", 32'(pop_pcs.size() != 0), 32'(1));
        if (gnt_addrs.size() != 0) check("redir_fetch_addr", 32'(gnt_addrs[0]), 32'h0100);
        if (pop_pcs.size() != 0) check("redir_first_pc", 32'(pop_pcs[0]), 32'h0100);

        // Redirect, response and pop all in one cycle.
        do_reset();
        gnt_pct = 100; lat_lo = 0; lat_hi = 0; rdy_pct = 0;
        for (int i = 0; i < 40 && !(last_gnt && instr_valid); i++) tick();
        check("wait_with_head", 32'(last_gnt && instr_valid), 32'(1));
        force_redir = 1'b1; force_pc = 16'h0200; rdy_pct = 100;
        gnt_addrs.delete(); pop_pcs.delete();
        tick();
        check("coincide_count", 32'(dbg_count), 32'(0));
        for (int i = 0; i < 40 && pop_pcs.size() == 0; i++) tick();
        check("coincide_pop_seen", 32'(pop_pcs.size() != 0), 32'(1));
        if (gnt_addrs.size() != 0) check("coincide_fetch_addr", 32'(gnt_addrs[0]), 32'h0200);
        if (pop_pcs.size() != 0) check("coincide_first_pc", 32'(pop_pcs[0]), 32'h0200);

        // Address wrap at the top of the address space.
        do_reset();
        gnt_pct = 100; lat_lo = 0; lat_hi = 0; rdy_pct = 100;
        force_redir = 1'b1; force_pc = 16'hFFFE;
        tick();
        gnt_addrs.delete(); pop_pcs.delete();
        for (int i = 0; i < 40 && pop_pcs.size() < 2; i++) tick();
        check("wrap_pops", 32'(pop_pcs.size() >= 2), 32'(1));
        if (gnt_addrs.size() >= 2) begin
            check("wrap_fetch0", 32'(gnt_addrs[0]), 32'hFFFE);
            check("wrap_fetch1", 32'(gnt_addrs[1]), 32'h0000);
        end
        if (pop_pcs.size() >= 2) begin
            check("wrap_pc0", 32'(pop_pcs[0]), 32'hFFFE);
            check("wrap_pc1", 32'(pop_pcs[1]), 32'h0000);
        end

        // Reset while a request waits for its grant.
        do_reset();
        gnt_pct = 0; rdy_pct = 100;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("in_req", 32'(mem_req), 32'(1));
        tick();
        rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_low", 32'(mem_req), 32'(0));
        check("rst_valid", 32'(instr_valid), 32'(0));
        check("rst_count", 32'(dbg_count), 32'(0));
        rst_n = 1'b1;
        clear_model();
        gnt_pct = 100;
        for (int i = 0; i < 20 && gnt_addrs.size() == 0; i++) tick();
        check("refetch_seen", 32'(gnt_addrs.size() != 0), 32'(1));
        if (gnt_addrs.size() != 0) check("refetch_addr", 32'(gnt_addrs[0]), 32'h0000);

        // Randomized grants, latencies, decoder stalls and redirects.
        do_reset();
        gnt_pct = 60; lat_lo = 0; lat_hi = 3; rdy_pct = 60; redir_pct = 4;
        repeat (3000) tick();
        check("random_progress", 32'(pop_pcs.size() > 100), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
